// File: rtl/keycode_event_queue.sv
// Turns the keycode PIO level into press/release/repeat events queued in a show-ahead FIFO.
// Define KEYCODE_TYPEMATIC_EN to build the auto-repeat counter and DELAY/REPEAT states.
module keycode_event_queue #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned CNT_W         = 25
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               keycode,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [7:0]               evt_code,
  output logic [1:0]               evt_kind,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_RELEASE = 2'b01;
  localparam logic [1:0] KIND_REPEAT  = 2'b10;

  // Elaboration-time parameter legality
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keycode_event_queue: DEPTH must be a power of two >= 2");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || CNT_W < 1 ||
      64'(REPEAT_DELAY - 1) >= (64'(1) << CNT_W) ||
      64'(REPEAT_PERIOD - 1) >= (64'(1) << CNT_W)) begin : g_bad_repeat
    $error("keycode_event_queue: REPEAT_DELAY/REPEAT_PERIOD must be >= 2 and fit CNT_W");
  end

`ifdef KEYCODE_TYPEMATIC_EN
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

  state_t      state, state_nxt;
  logic [7:0]  cur;
  logic [7:0]  held, held_nxt;
  logic        push;
  logic [7:0]  push_code;
  logic [1:0]  push_kind;
`ifdef KEYCODE_TYPEMATIC_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

  // Input level register and tracker state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur   <= 8'h00;
      held  <= 8'h00;
      state <= ST_IDLE;
`ifdef KEYCODE_TYPEMATIC_EN
      cnt   <= '0;
`endif
    end else begin
      cur   <= keycode;
      held  <= held_nxt;
      state <= state_nxt;
`ifdef KEYCODE_TYPEMATIC_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  // Event selection: release beats press beats typematic repeat
  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    push      = 1'b0;
    push_code = 8'h00;
    push_kind = KIND_PRESS;
`ifdef KEYCODE_TYPEMATIC_EN
    cnt_nxt   = cnt;
`endif
    if (state != ST_IDLE && cur != held) begin
      push      = 1'b1;
      push_code = held;
      push_kind = KIND_RELEASE;
      held_nxt  = 8'h00;
      state_nxt = ST_IDLE;
`ifdef KEYCODE_TYPEMATIC_EN
      cnt_nxt   = '0;
`endif
    end else if (state == ST_IDLE && cur != 8'h00) begin
      push      = 1'b1;
      push_code = cur;
      push_kind = KIND_PRESS;
      held_nxt  = cur;
`ifdef KEYCODE_TYPEMATIC_EN
      state_nxt = ST_DELAY;
      cnt_nxt   = '0;
`else
      state_nxt = ST_HELD;
`endif
    end
`ifdef KEYCODE_TYPEMATIC_EN
    else if (state == ST_DELAY || state == ST_REPEAT) begin
      // Here cur == held, so the key is still down
      if ((state == ST_DELAY  && cnt == CNT_W'(REPEAT_DELAY - 1)) ||
          (state == ST_REPEAT && cnt == CNT_W'(REPEAT_PERIOD - 1))) begin
        push      = 1'b1;
        push_code = held;
        push_kind = KIND_REPEAT;
        cnt_nxt   = '0;
        state_nxt = ST_REPEAT;
      end else begin
        cnt_nxt   = cnt + CNT_W'(1);
      end
    end
`endif
  end

  logic [7:0]       mem_code [DEPTH];
  logic [1:0]       mem_kind [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             pop, accept, drop;

  assign pop    = evt_valid && evt_ready;
  assign accept = push && ((fifo_level < LVL_W'(DEPTH)) || pop);
  assign drop   = push && !accept;

  // Show-ahead FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_code[i] <= 8'h00;
        mem_kind[i] <= 2'b00;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (accept) begin
        mem_code[wr_ptr] <= push_code;
        mem_kind[wr_ptr] <= push_kind;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Sticky drop flag; a new drop outranks the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign evt_valid = (fifo_level != '0);
  assign evt_code  = mem_code[rd_ptr];
  assign evt_kind  = mem_kind[rd_ptr];

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue: DEPTH=4, REPEAT_DELAY=10, REPEAT_PERIOD=4.
module tb_keycode_event_queue;

  localparam logic [1:0] K_PRESS   = 2'b00;
  localparam logic [1:0] K_RELEASE = 2'b01;
  localparam logic [1:0] K_REPEAT  = 2'b10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keycode;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic [1:0] evt_kind;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       overflow_clr;

  keycode_event_queue #(
    .DEPTH(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .keycode(keycode),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_kind(evt_kind),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
    logic [7:0] code;
  } ev_t;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  ev_t cap_q[$];

  always @(posedge clk) cyc++;

  // Record every popped event with the edge index at which it was written
  always @(negedge clk) begin
    if (reset_n && evt_valid && evt_ready)
      cap_q.push_back('{cyc: cyc, kind: evt_kind, code: evt_code});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input string tag, input logic [7:0] code,
                            input logic [1:0] kind, input int at_cyc);
    ev_t e;
    if (cap_q.size() == 0) begin
      chk({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      e = cap_q.pop_front();
      chk({tag, "_code"}, 32'(e.code), 32'(code));
      chk({tag, "_kind"}, 32'(e.kind), 32'(kind));
      if (at_cyc >= 0) chk({tag, "_cyc"}, 32'(e.cyc), 32'(at_cyc));
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    evt_ready = 1'b1;
    while (fifo_level != 3'd0 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 32'(fifo_level), 32'd0);
    repeat (2) tick();
  endtask

  int c0;

  initial begin
    reset_n = 1'b0; keycode = 8'h00; evt_ready = 1'b1; overflow_clr = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_code", 32'(evt_code), 32'd0);
    chk("rst_kind", 32'(evt_kind), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Press and release
    cap_q.delete();
    c0 = cyc;
    keycode = 8'h1C; repeat (3) tick();
    keycode = 8'h00; repeat (5) tick();
    expect_evt("t1_press", 8'h1C, K_PRESS, c0 + 2);
    expect_evt("t1_rel", 8'h1C, K_RELEASE, c0 + 5);
    chk("t1_extra", 32'(cap_q.size()), 32'd0);

    // Direct change A->B
    c0 = cyc;
    keycode = 8'h04; repeat (3) tick();
    keycode = 8'h05; repeat (3) tick();
    keycode = 8'h00; repeat (5) tick();
    expect_evt("t2_press_a", 8'h04, K_PRESS, c0 + 2);
    expect_evt("t2_rel_a", 8'h04, K_RELEASE, c0 + 5);
    expect_evt("t2_press_b", 8'h05, K_PRESS, c0 + 6);
    expect_evt("t2_rel_b", 8'h05, K_RELEASE, c0 + 8);
    chk("t2_extra", 32'(cap_q.size()), 32'd0);

    // Typematic hold
    c0 = cyc;
    keycode = 8'h29; repeat (30) tick();
    keycode = 8'h00; repeat (5) tick();
    expect_evt("t3_press", 8'h29, K_PRESS, c0 + 2);
`ifdef KEYCODE_TYPEMATIC_EN
    for (int k = 0; k < 5; k++)
      expect_evt($sformatf("t3_rep%0d", k), 8'h29, K_REPEAT, c0 + 12 + 4 * k);
`endif
    expect_evt("t3_rel", 8'h29, K_RELEASE, c0 + 32);
    chk("t3_extra", 32'(cap_q.size()), 32'd0);
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Overflow with consumer stalled: six events, first four kept
    evt_ready = 1'b0;
    keycode = 8'h10; repeat (3) tick();
    keycode = 8'h11; repeat (3) tick();
    keycode = 8'h12; repeat (3) tick();
    keycode = 8'h00; repeat (4) tick();
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_valid", 32'(evt_valid), 32'd1);
    chk("t4_head_code", 32'(evt_code), 32'h10);
    chk("t4_head_kind", 32'(evt_kind), 32'(K_PRESS));
    overflow_clr = 1'b1; tick();
    overflow_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    drain("t4");
    expect_evt("t4_e0", 8'h10, K_PRESS, -1);
    expect_evt("t4_e1", 8'h10, K_RELEASE, -1);
    expect_evt("t4_e2", 8'h11, K_PRESS, -1);
    expect_evt("t4_e3", 8'h11, K_RELEASE, -1);
    chk("t4_extra", 32'(cap_q.size()), 32'd0);

    // Full FIFO with simultaneous pop and push
    evt_ready = 1'b0;
    cap_q.delete();
    keycode = 8'h20; repeat (3) tick();
    keycode = 8'h00; repeat (3) tick();
    keycode = 8'h21; repeat (3) tick();
    keycode = 8'h00; repeat (4) tick();
    chk("t5_full", 32'(fifo_level), 32'd4);
    keycode = 8'h22; tick();
    evt_ready = 1'b1; tick();
    evt_ready = 1'b0;
    chk("t5_level", 32'(fifo_level), 32'd4);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_head_code", 32'(evt_code), 32'h20);
    chk("t5_head_kind", 32'(evt_kind), 32'(K_RELEASE));
    keycode = 8'h00;
    drain("t5");
    expect_evt("t5_e0", 8'h20, K_PRESS, -1);
    expect_evt("t5_e1", 8'h20, K_RELEASE, -1);
    expect_evt("t5_e2", 8'h21, K_PRESS, -1);
    expect_evt("t5_e3", 8'h21, K_RELEASE, -1);
    expect_evt("t5_e4", 8'h22, K_PRESS, -1);
    expect_evt("t5_e5", 8'h22, K_RELEASE, -1);
    chk("t5_extra", 32'(cap_q.size()), 32'd0);

    // Asynchronous reset mid-operation
    evt_ready = 1'b0;
    cap_q.delete();
    keycode = 8'h30; repeat (3) tick();
    keycode = 8'h00; repeat (3) tick();
    keycode = 8'h31; repeat (3) tick();
    chk("t6_level_pre", 32'(fifo_level), 32'd3);
    keycode = 8'h1C;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(evt_valid), 32'd0);
    chk("t6_level_rst", 32'(fifo_level), 32'd0);
    chk("t6_ovf_rst", 32'(overflow), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    c0 = cyc;
    evt_ready = 1'b1;
    repeat (4) tick();
    expect_evt("t6_press", 8'h1C, K_PRESS, c0 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
